// File: rtl/data_memory_pkg.sv
// Shared constants for the CPU data memory: access-size encodings and default widths.
// Imported by the lane controller and the data_memory top.
package data_memory_pkg;

    localparam int MEM_DATA_WIDTH  = 32;
    localparam int MEM_DEPTH_WORDS = 64;

    typedef enum logic [1:0] {
        MEM_MODE_WORD = 2'b00,
        MEM_MODE_HALF = 2'b01,
        MEM_MODE_BYTE = 2'b10,
        MEM_MODE_RSVD = 2'b11
    } mem_mode_e;

endpackage

// File: rtl/data_mem_lane_ctl.sv
// Combinational byte-lane steering: maps address[1:0] and access size onto lane write
// enables, lane-replicated store data, and the load shift/size controls.
module data_mem_lane_ctl
    import data_memory_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_mode,
    input  logic [31:0] i_raw_data,
    output logic [3:0]  o_lane_we,
    output logic [31:0] o_lane_wdat,
    output logic [1:0]  o_ld_shift,
    output logic        o_ld_half,
    output logic        o_ld_byte,
    output logic        o_ld_zero
);

    always_comb begin
        o_lane_we   = 4'b0000;
        o_lane_wdat = 32'h0;
        o_ld_shift  = 2'b00;
        o_ld_half   = 1'b0;
        o_ld_byte   = 1'b0;
        o_ld_zero   = 1'b0;
        case (i_mode)
            MEM_MODE_WORD: begin
                o_lane_we   = 4'b1111;
                o_lane_wdat = i_raw_data;
            end
            MEM_MODE_HALF: begin
                // bit 0 is dropped: halfwords are forced onto lanes 0-1 or 2-3
                o_lane_we   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_lane_wdat = {2{i_raw_data[15:0]}};
                o_ld_shift  = {i_addr_lo[1], 1'b0};
                o_ld_half   = 1'b1;
            end
            MEM_MODE_BYTE: begin
                o_lane_we   = 4'b0001 << i_addr_lo;
                o_lane_wdat = {4{i_raw_data[7:0]}};
                o_ld_shift  = i_addr_lo;
                o_ld_byte   = 1'b1;
            end
            default: begin
                o_ld_zero   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory: four byte-wide banks, synchronous write,
// read-first registered load (1 cycle). Sub-word loads sign-extend when DATA_MEM_SIGN_EXT_EN is defined.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int DEPTH_WORDS = MEM_DEPTH_WORDS
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] raw_data,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic                  wren,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int AW = $clog2(4 * DEPTH_WORDS);
    localparam int RW = AW - 2;

`ifdef DATA_MEM_SIGN_EXT_EN
    localparam bit SIGN_EXT = 1'b1;
`else
    localparam bit SIGN_EXT = 1'b0;
`endif

    logic [3:0]    w_lane_we;
    logic [3:0]    w_bank_we;
    logic [31:0]   w_lane_wdat;
    logic [1:0]    w_ld_shift;
    logic          w_ld_half;
    logic          w_ld_byte;
    logic          w_ld_zero;
    logic [RW-1:0] w_row;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_shifted;
    logic [31:0]   w_ld;
    logic          w_unused_addr;
    logic [DATA_WIDTH-1:0] r_q;

    // upper address bits are ignored so accesses wrap around the array
    assign w_row         = address[AW-1:2];
    assign w_unused_addr = ^address[DATA_WIDTH-1:AW];

    data_mem_lane_ctl u_lane_ctl (
        .i_addr_lo   (address[1:0]),
        .i_mode      (mode),
        .i_raw_data  (raw_data[31:0]),
        .o_lane_we   (w_lane_we),
        .o_lane_wdat (w_lane_wdat),
        .o_ld_shift  (w_ld_shift),
        .o_ld_half   (w_ld_half),
        .o_ld_byte   (w_ld_byte),
        .o_ld_zero   (w_ld_zero)
    );

    assign w_bank_we = w_lane_we & {4{wren & ~reset}};

    for (genvar g = 0; g < 4; g++) begin : g_bank
        logic [7:0] r_mem [DEPTH_WORDS];

        always_ff @(posedge clock) begin
            if (w_bank_we[g]) begin
                r_mem[w_row] <= w_lane_wdat[8*g +: 8];
            end
        end

        // combinational read feeding r_q gives read-first on a same-address write
        assign w_rd_word[8*g +: 8] = r_mem[w_row];
    end

    assign w_shifted = w_rd_word >> {w_ld_shift, 3'b000};

    always_comb begin
        w_ld = w_shifted;
        if (w_ld_zero) begin
            w_ld = 32'h0;
        end else if (w_ld_half) begin
            w_ld = {{16{SIGN_EXT & w_shifted[15]}}, w_shifted[15:0]};
        end else if (w_ld_byte) begin
            w_ld = {{24{SIGN_EXT & w_shifted[7]}}, w_shifted[7:0]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_ld;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboarded bench for data_memory: a byte-array reference model predicts each load,
// a monitor compares q one cycle after every issued access.
module tb_data_memory;

    localparam int RATE = 10;

`ifdef DATA_MEM_SIGN_EXT_EN
    localparam bit SX = 1'b1;
`else
    localparam bit SX = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] raw_data = 32'h0;
    logic [31:0] address = 32'h0;
    logic        wren = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] q;

    logic [7:0]  mm [256];
    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          n_chk = 0;
    int          n_fail = 0;

    always #(RATE/2) clock = ~clock;

    data_memory dut (
        .clock    (clock),
        .reset    (reset),
        .raw_data (raw_data),
        .address  (address),
        .wren     (wren),
        .mode     (mode),
        .q        (q)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: q=%08h expected %08h", nm, act, exp);
        end
    endtask

    // Reference model: plain byte array, little-endian, alignment by masking.
    function automatic logic [31:0] model_read(input logic [1:0] md, input logic [31:0] ad);
        int a;
        logic [15:0] h;
        logic [7:0]  b;
        a = int'(ad & 32'hFF);
        case (md)
            2'b00: begin
                a = a & ~3;
                return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
            end
            2'b01: begin
                a = a & ~1;
                h = {mm[a+1], mm[a]};
                return (SX && h[15]) ? {16'hFFFF, h} : {16'h0000, h};
            end
            2'b10: begin
                b = mm[a];
                return (SX && b[7]) ? {24'hFFFFFF, b} : {24'h000000, b};
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [1:0] md, input logic [31:0] ad, input logic [31:0] dt);
        int a;
        a = int'(ad & 32'hFF);
        case (md)
            2'b00: begin
                a = a & ~3;
                for (int i = 0; i < 4; i++) mm[a+i] = dt[8*i +: 8];
            end
            2'b01: begin
                a = a & ~1;
                mm[a]   = dt[7:0];
                mm[a+1] = dt[15:8];
            end
            2'b10: mm[a] = dt[7:0];
            default: ;
        endcase
    endtask

    // One access cycle; the load result is queued for the monitor when chk is set.
    task automatic cyc(input string nm, input bit chk, input logic w, input logic [1:0] md,
                       input logic [31:0] ad, input logic [31:0] dt);
        @(negedge clock);
        wren = w; mode = md; address = ad; raw_data = dt;
        if (chk) begin
            exp_q.push_back(model_read(md, ad));
            tag_q.push_back(nm);
        end
        if (w && !reset) model_write(md, ad, dt);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) check(tag_q.pop_front(), q, exp_q.pop_front());
        end
    end

    initial begin : watchdog
        #(RATE * 20000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int i = 0; i < 256; i++) mm[i] = 8'h00;

        // T1: reset asserted; attempted writes must be blocked
        #2 reset = 1'b1;
        #1 check("reset_q", q, 32'h0);
        @(negedge clock);
        wren = 1'b1; mode = 2'b00; address = 32'h20; raw_data = 32'hDEADBEEF;
        @(negedge clock);
        check("reset_hold_q", q, 32'h0);
        reset = 1'b0;
        wren = 1'b0;

        for (int i = 0; i < 64; i++) cyc("init", 1'b0, 1'b1, 2'b00, 32'(4*i), 32'h0);
        cyc("init_last", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        cyc("t1_nowrite", 1'b1, 1'b0, 2'b00, 32'h20, 32'h0);

        // T2..T4: directed sub-word cases
        cyc("t2_wr",   1'b0, 1'b1, 2'b00, 32'd3, 32'h555555D5);
        cyc("t2_rdw",  1'b1, 1'b0, 2'b00, 32'd3, 32'h555555D5);
        cyc("t2_rdh",  1'b1, 1'b0, 2'b01, 32'd3, 32'h555555D5);
        cyc("t2_rdb",  1'b1, 1'b0, 2'b10, 32'd3, 32'h555555D5);
        cyc("t3_wr",   1'b0, 1'b1, 2'b01, 32'd5, 32'h555555D5);
        cyc("t3_rdw",  1'b1, 1'b0, 2'b00, 32'd4, 32'h555555D5);
        cyc("t3_rdb",  1'b1, 1'b0, 2'b10, 32'd4, 32'h555555D5);
        cyc("t4_wr",   1'b0, 1'b1, 2'b10, 32'd9, 32'h555555D5);
        cyc("t4_rdw",  1'b1, 1'b0, 2'b00, 32'd8, 32'h555555D5);
        cyc("t4_rd13", 1'b1, 1'b0, 2'b00, 32'd13, 32'h555555D5);
        // T5: read-first on same-address write, then reserved mode
        cyc("t5_rfw",  1'b1, 1'b1, 2'b00, 32'd0, 32'hAAAAAAAA);
        cyc("t5_new",  1'b1, 1'b0, 2'b00, 32'd0, 32'h555555D5);
        cyc("t5_rsvd", 1'b1, 1'b1, 2'b11, 32'd0, 32'h12345678);
        cyc("t5_keep", 1'b1, 1'b0, 2'b00, 32'd0, 32'h555555D5);
        cyc("wrap",    1'b1, 1'b0, 2'b00, 32'h00000104, 32'h0);
        cyc("hi_sign", 1'b1, 1'b0, 2'b10, 32'h00000004, 32'h0);

        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                $urandom, $urandom);
        end

        // T6: asynchronous reset mid-cycle, contents retained
        cyc("t6_wr", 1'b0, 1'b1, 2'b00, 32'h40, 32'h11223344);
        cyc("t6_rd", 1'b1, 1'b0, 2'b00, 32'h40, 32'h0);
        @(posedge clock);
        #3 reset = 1'b1;
        #1 check("t6_async_q", q, 32'h0);
        @(negedge clock);
        wren = 1'b1; mode = 2'b00; address = 32'h40; raw_data = 32'hCAFEF00D;
        @(posedge clock);
        #1 check("t6_hold_q", q, 32'h0);
        #2 reset = 1'b0;
        wren = 1'b0;
        cyc("t6_after", 1'b1, 1'b0, 2'b00, 32'h40, 32'h0);
        cyc("t6_after_b", 1'b1, 1'b0, 2'b10, 32'h43, 32'h0);

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d loads never compared, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
